// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the shared-ALU arbiter.
//   ALU_CTRL_W  width of the ALU op code
//   alu_op_e    ALU op codes understood by the external ALU
//   arb_slot_e  per-requester slot state (IDLE -> INFLIGHT -> RESP)
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLL  = 4'd5,
    SRA  = 4'd6,
    SRL  = 4'd7,
    SLT  = 4'd8,
    SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    RESP     = 2'd2
  } arb_slot_e;

endpackage

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: combinational grant picker for the shared ALU.
//   elig_i        eligible requesters
//   last_grant_i  previous winner (only with ALU_ARB_RR_EN)
//   gnt_o         one-hot grant, zero when nobody is eligible
//   gnt_idx_o     index of the winner (0 when no grant)
// Macro ALU_ARB_RR_EN: defined -> round-robin starting after last_grant_i;
// undefined -> fixed priority, lowest index wins.
module alu_arb_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] elig_i,
`ifdef ALU_ARB_RR_EN
  input  logic [IDX_W-1:0]   last_grant_i,
`endif
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

`ifdef ALU_ARB_RR_EN
  int   cand;
  logic found;

  // Walk last+1, last+2, ... wrapping; first eligible candidate wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && elig_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = IDX_W'(cand);
      end
    end
  end
`else
  // Scan from the top down so the lowest eligible index is the last writer.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig_i[i]) begin
        gnt_o     = '0;
        gnt_o[i]  = 1'b1;
        gnt_idx_o = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU among NUM_REQ requesters.
//   clk_i/rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o  request handshake; ready is a one-hot grant
//   req_ctrl_i/op1/op2   per-requester op code and operands (flattened slices)
//   rsp_valid_o/ready_i  per-requester result handshake
//   rsp_data_o           per-requester result slot
//   alu_ctrl_o/op1/op2   registered ALU inputs (zero when no op is issued)
//   alu_out_i            ALU combinational result
// Macro ALU_ARB_RR_EN: round-robin arbitration; otherwise fixed priority (req 0 highest).
// Timing: grant in cycle N, ALU driven in N+1 and result captured, rsp_valid_o in N+2.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*ALU_CTRL_W-1:0] req_ctrl_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data_o,
  output logic [ALU_CTRL_W-1:0]         alu_ctrl_o,
  output logic [DATA_WIDTH-1:0]         alu_op1_o,
  output logic [DATA_WIDTH-1:0]         alu_op2_o,
  input  logic [DATA_WIDTH-1:0]         alu_out_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_slot_e                          state_q [NUM_REQ];
  arb_slot_e                          state_d [NUM_REQ];
  logic [NUM_REQ-1:0]                 elig;
  logic [NUM_REQ-1:0]                 gnt;
  logic [IDX_W-1:0]                   gnt_idx;
  logic                               fire;

  logic                               issue_v_q;
  logic [IDX_W-1:0]                   tag_q;
  logic [ALU_CTRL_W-1:0]              ctrl_q;
  logic [DATA_WIDTH-1:0]              op1_q;
  logic [DATA_WIDTH-1:0]              op2_q;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_q;

  // Eligibility uses only req_valid_i and registered state, so rsp_ready_i
  // never reaches req_ready_o and the drain cycle is never eligible.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_valid_i[i] && (state_q[i] == IDLE);
  end

`ifdef ALU_ARB_RR_EN
  logic [IDX_W-1:0] last_grant_q;

  // Reset value NUM_REQ-1 makes requester 0 the first winner.
  always_ff @(posedge clk_i) begin
    if (rst_i)     last_grant_q <= IDX_W'(NUM_REQ - 1);
    else if (fire) last_grant_q <= gnt_idx;
  end
`endif

  alu_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .elig_i       (elig),
`ifdef ALU_ARB_RR_EN
    .last_grant_i (last_grant_q),
`endif
    .gnt_o        (gnt),
    .gnt_idx_o    (gnt_idx)
  );

  assign fire        = |gnt;
  assign req_ready_o = gnt;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE:     if (gnt[i]) state_d[i] = INFLIGHT;
        INFLIGHT: if (issue_v_q && tag_q == IDX_W'(i)) state_d[i] = RESP;
        RESP:     if (rsp_ready_i[i]) state_d[i] = IDLE;
        default:  state_d[i] = IDLE;
      endcase
    end
  end

  // Issue register is cleared on idle cycles so the ALU sees ADD 0+0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_v_q <= 1'b0;
      tag_q     <= '0;
      ctrl_q    <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      data_q    <= '0;
      for (int i = 0; i < NUM_REQ; i++) state_q[i] <= IDLE;
    end else begin
      issue_v_q <= fire;
      tag_q     <= fire ? gnt_idx : '0;
      ctrl_q    <= fire ? req_ctrl_i[int'(gnt_idx)*ALU_CTRL_W +: ALU_CTRL_W] : '0;
      op1_q     <= fire ? req_op1_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
      op2_q     <= fire ? req_op2_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        state_q[i] <= state_d[i];
        if (issue_v_q && tag_q == IDX_W'(i)) data_q[i] <= alu_out_i;
      end
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid_o[i] = (state_q[i] == RESP);
  end

  assign rsp_data_o = data_q;
  assign alu_ctrl_o = ctrl_q;
  assign alu_op1_o  = op1_q;
  assign alu_op2_o  = op2_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed, table-driven bench for alu_share_arbiter
// with a behavioural ALU on the alu_* ports.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int NR = 2;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*4-1:0]  req_ctrl;
  logic [NR*DW-1:0] req_op1;
  logic [NR*DW-1:0] req_op2;
  logic [NR-1:0]    rsp_valid;
  logic [NR-1:0]    rsp_ready;
  logic [NR*DW-1:0] rsp_data;
  logic [3:0]       alu_ctrl;
  logic [DW-1:0]    alu_op1;
  logic [DW-1:0]    alu_op2;
  logic [DW-1:0]    alu_out;

  int n_chk  = 0;
  int n_fail = 0;

  alu_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_ctrl_i  (req_ctrl),
    .req_op1_i   (req_op1),
    .req_op2_i   (req_op2),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .alu_ctrl_o  (alu_ctrl),
    .alu_op1_o   (alu_op1),
    .alu_op2_o   (alu_op2),
    .alu_out_i   (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model; undefined codes give 0.
  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      ADD:  alu_out = alu_op1 + alu_op2;
      SUB:  alu_out = alu_op1 - alu_op2;
      AND:  alu_out = alu_op1 & alu_op2;
      OR:   alu_out = alu_op1 | alu_op2;
      XOR:  alu_out = alu_op1 ^ alu_op2;
      SLL:  alu_out = alu_op1 << alu_op2[4:0];
      SRA:  alu_out = $signed(alu_op1) >>> alu_op2[4:0];
      SRL:  alu_out = alu_op1 >> alu_op2[4:0];
      SLT:  alu_out = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
      SLTU: alu_out = {31'd0, alu_op1 < alu_op2};
      default: alu_out = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int r, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_ctrl[4*r +: 4]  = c;
    req_op1[DW*r +: DW] = a;
    req_op2[DW*r +: DW] = b;
  endtask

  // One isolated op on requester r, checked at each pipeline step.
  task automatic do_op(input int r, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e);
    @(negedge clk);
    req_valid    = '0;
    req_valid[r] = 1'b1;
    set_req(r, c, a, b);
    #1 chk("grant", 32'(req_ready), 32'(1 << r));
    @(negedge clk);
    req_valid = '0;
    chk("alu_ctrl", 32'(alu_ctrl), 32'(c));
    chk("alu_op1", alu_op1, a);
    chk("rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(1 << r));
    chk("rsp_data", rsp_data[DW*r +: DW], e);
    @(negedge clk);
    chk("rsp_drain", 32'(rsp_valid), 32'd0);
    chk("alu_idle", 32'(alu_ctrl) | alu_op1 | alu_op2, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int         r;
    logic [3:0] c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t vecs [8];

  logic [NR-1:0] exp_rdy [9];
  logic [NR-1:0] exp_vld [9];
  logic [NR-1:0] exp_first;

  initial begin
    vecs[0] = '{0, SUB,   32'd10,        32'd3,         32'd7};
    vecs[1] = '{1, SRA,   32'h8000_0000, 32'd4,         32'hF800_0000};
    vecs[2] = '{0, SLT,   32'hFFFF_FFFF, 32'd1,         32'd1};
    vecs[3] = '{1, 4'hF,  32'd5,         32'd6,         32'd0};
    vecs[4] = '{0, ADD,   32'd3,         32'd4,         32'd7};
    vecs[5] = '{1, XOR,   32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00};
    vecs[6] = '{0, SLL,   32'd1,         32'd31,        32'h8000_0000};
    vecs[7] = '{1, SRL,   32'h8000_0000, 32'd31,        32'd1};

    exp_rdy = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    exp_vld = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
`ifdef ALU_ARB_RR_EN
    exp_first = 2'b10;
`else
    exp_first = 2'b01;
`endif

    rst       = 1'b1;
    req_valid = '0;
    req_ctrl  = '0;
    req_op1   = '0;
    req_op2   = '0;
    rsp_ready = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data[31:0] | rsp_data[63:32], 32'd0);
    chk("rst_alu", 32'(alu_ctrl) | alu_op1 | alu_op2, 32'd0);

    // Reset mid-flight: grant ADD 3+4, reset in N+1, op must vanish.
    @(negedge clk);
    req_valid = 2'b01;
    set_req(0, ADD, 32'd3, 32'd4);
    #1 chk("mf_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    chk("mf_alu_op1", alu_op1, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mf_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mf_rsp_data", rsp_data[31:0], 32'd0);
    chk("mf_alu", 32'(alu_ctrl) | alu_op1 | alu_op2, 32'd0);
    @(negedge clk);
    chk("mf_rsp_valid2", 32'(rsp_valid), 32'd0);

    // Table of single ops across both requesters
    for (int i = 0; i < 8; i++)
      do_op(vecs[i].r, vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].e);

    // Backpressure on requester 1 with valid held high
    @(negedge clk);
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    set_req(1, SLTU, 32'd1, 32'hFFFF_FFFF);
    #1 chk("bp_grant", 32'(req_ready), 32'b10);
    @(negedge clk);
    chk("bp_inflight_rdy", 32'(req_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid[1]), 32'd1);
      chk("bp_data", rsp_data[DW +: DW], 32'd1);
      chk("bp_ready", 32'(req_ready[1]), 32'd0);
    end
    rsp_ready = 2'b11;
    #1 chk("bp_drain_rdy", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp_after_valid", 32'(rsp_valid), 32'd0);
    chk("bp_regrant", 32'(req_ready), 32'b10);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);

    // Contention from reset: both always valid
    do_reset();
    set_req(0, ADD, 32'd1, 32'd2);
    set_req(1, SUB, 32'd9, 32'd4);
    req_valid = 2'b11;
    for (int t = 0; t < 9; t++) begin
      #1;
      chk("ct_ready", 32'(req_ready), 32'(exp_rdy[t]));
      chk("ct_valid", 32'(rsp_valid), 32'(exp_vld[t]));
      @(negedge clk);
    end
    chk("ct_data0", rsp_data[31:0], 32'd3);
    chk("ct_data1", rsp_data[63:32], 32'd5);
    req_valid = '0;
    repeat (4) @(negedge clk);

    // Arbitration policy: req0 alone first, then both compete
    do_reset();
    req_valid = 2'b01;
    #1 chk("pol_first", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    req_valid = 2'b11;
    #1 chk("pol_pick", 32'(req_ready), 32'(exp_first));
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("end_idle", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
